// File: rtl/swerv_trace_serializer_if.sv
// Retirement-trace packet type and the trace/record interface of the serializer.
//   trace_pkt   up to 3 retired lanes per cycle; lane k = bits [32k+31:32k] of insn/address
//   trace_en    1 = accept packets
//   out_*       one record per cycle, valid/ready handshake toward the trace sink
// Modports: slave = serializer side, master = core/sink side.

typedef struct packed {
    logic [95:0] trace_rv_i_insn_ip;
    logic [95:0] trace_rv_i_address_ip;
    logic [2:0]  trace_rv_i_valid_ip;
    logic [2:0]  trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic [2:0]  trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
} trace_pkt_t;

interface swerv_trace_serializer_if;
    trace_pkt_t  trace_pkt;
    logic        trace_en;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_lane;
    logic [31:0] out_insn;
    logic [31:0] out_addr;
    logic        out_exc;
    logic        out_intr;
    logic [4:0]  out_ecause;
    logic [31:0] out_tval;

    modport slave (
        input  trace_pkt, trace_en, out_ready,
        output out_valid, out_lane, out_insn, out_addr, out_exc, out_intr,
               out_ecause, out_tval
    );

    modport master (
        output trace_pkt, trace_en, out_ready,
        input  out_valid, out_lane, out_insn, out_addr, out_exc, out_intr,
               out_ecause, out_tval
    );
endinterface

// File: rtl/swerv_trace_serializer.sv
// Serializes the 3-lane retirement trace packet into a one-record-per-cycle
// valid/ready stream. Valid lanes are buffered in a circular FIFO; a packet
// that does not fit in the free space is dropped whole and its lanes counted.
// Ports:
//   clk, rst_l   clock, async active-low reset
//   tif          trace packet in / record stream out (slave modport)
//   ovf_clr      clears ovf and drop_cnt (a same-cycle drop takes priority)
//   fifo_cnt     occupied entries
//   ovf          sticky packet-dropped flag
//   drop_cnt     dropped lanes, saturating

module swerv_trace_serializer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_l,
    swerv_trace_serializer_if.slave  tif,
    input  logic                     ovf_clr,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     ovf,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]  lane;
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [2:0]      lane_vld;
    logic [1:0]      n_lanes;
    logic [AW:0]     n_ext;
    logic [AW:0]     free;
    logic            fit;
    logic            pop;
    logic [1:0]      lane_off [3];
    logic [AW-1:0]   wr_idx   [3];
    entry_t          lane_entry [3];
    logic [CNT_W:0]  drop_sum;

    // ---------------- push side ----------------
    assign lane_vld = tif.trace_en ? tif.trace_pkt.trace_rv_i_valid_ip : 3'b000;
    assign n_lanes  = {1'b0, lane_vld[0]} + {1'b0, lane_vld[1]} + {1'b0, lane_vld[2]};
    assign n_ext    = (AW+1)'(n_lanes);
    // Free space is taken from the registered count only; a pop in the same
    // cycle does not make room for this cycle's packet.
    assign free     = (AW+1)'(DEPTH) - cnt_q;
    assign fit      = (n_ext <= free);

    // Valid lanes are packed densely: each lane's slot is offset by the
    // number of valid lanes below it.
    always_comb begin
        lane_off[0] = 2'd0;
        lane_off[1] = {1'b0, lane_vld[0]};
        lane_off[2] = {1'b0, lane_vld[0]} + {1'b0, lane_vld[1]};
        for (int k = 0; k < 3; k++) begin
            wr_idx[k] = wr_ptr_q + AW'(lane_off[k]);
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_lane
        logic trap;
        assign trap = tif.trace_pkt.trace_rv_i_exception_ip[k] |
                      tif.trace_pkt.trace_rv_i_interrupt_ip[k];
        assign lane_entry[k].lane   = 2'(k);
        assign lane_entry[k].insn   = tif.trace_pkt.trace_rv_i_insn_ip[32*k +: 32];
        assign lane_entry[k].addr   = tif.trace_pkt.trace_rv_i_address_ip[32*k +: 32];
        assign lane_entry[k].exc    = tif.trace_pkt.trace_rv_i_exception_ip[k];
        assign lane_entry[k].intr   = tif.trace_pkt.trace_rv_i_interrupt_ip[k];
        assign lane_entry[k].ecause = trap ? tif.trace_pkt.trace_rv_i_ecause_ip : 5'd0;
        assign lane_entry[k].tval   = trap ? tif.trace_pkt.trace_rv_i_tval_ip : 32'd0;
    end

    // ---------------- pop side ----------------
    assign pop = tif.out_valid & tif.out_ready;

    // ---------------- next state ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + (fit ? AW'(n_lanes) : '0);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + (fit ? n_ext : '0) - (AW+1)'(pop);
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        drop_sum = '0;
        if (ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
        // Applied after the clear so a same-cycle drop wins.
        if (!fit) begin
            ovf_d    = 1'b1;
            drop_sum = {1'b0, drop_d} + (CNT_W+1)'(n_lanes);
            drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is cleared on reset so the record outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (fit) begin
            for (int k = 0; k < 3; k++) begin
                if (lane_vld[k]) mem_q[wr_idx[k]] <= lane_entry[k];
            end
        end
    end

    // ---------------- outputs ----------------
    assign tif.out_valid  = (cnt_q != '0);
    assign tif.out_lane   = mem_q[rd_ptr_q].lane;
    assign tif.out_insn   = mem_q[rd_ptr_q].insn;
    assign tif.out_addr   = mem_q[rd_ptr_q].addr;
    assign tif.out_exc    = mem_q[rd_ptr_q].exc;
    assign tif.out_intr   = mem_q[rd_ptr_q].intr;
    assign tif.out_ecause = mem_q[rd_ptr_q].ecause;
    assign tif.out_tval   = mem_q[rd_ptr_q].tval;

    assign fifo_cnt = cnt_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_swerv_trace_serializer.sv
// Bench for swerv_trace_serializer: directed scenarios plus a randomized run
// against a queue-based reference model of the FIFO and drop counter.

module tb_swerv_trace_serializer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        ovf_clr;
    logic [3:0]  fifo_cnt;
    logic        ovf;
    logic [15:0] drop_cnt;

    swerv_trace_serializer_if tif();

    swerv_trace_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .tif      (tif),
        .ovf_clr  (ovf_clr),
        .fifo_cnt (fifo_cnt),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  lane;
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic        intr;
        logic [4:0]  ec;
        logic [31:0] tval;
    } rec_t;

    rec_t q[$];
    bit   m_ovf;
    int   m_drop;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: advance one clock using the currently applied inputs.
    task automatic tick();
        int   n, free;
        bit   pop;
        rec_t r;
        trace_pkt_t p;
        p    = tif.trace_pkt;
        pop  = (q.size() != 0) && tif.out_ready;
        n    = tif.trace_en ? $countones(p.trace_rv_i_valid_ip) : 0;
        free = DEPTH - q.size();
        if (pop) void'(q.pop_front());
        if (ovf_clr) begin m_ovf = 0; m_drop = 0; end
        if (n > free) begin
            m_ovf  = 1;
            m_drop = (m_drop + n > MAXC) ? MAXC : m_drop + n;
        end else if (n > 0) begin
            for (int k = 0; k < 3; k++) begin
                if (p.trace_rv_i_valid_ip[k]) begin
                    r.lane = 2'(k);
                    r.insn = p.trace_rv_i_insn_ip[32*k +: 32];
                    r.addr = p.trace_rv_i_address_ip[32*k +: 32];
                    r.exc  = p.trace_rv_i_exception_ip[k];
                    r.intr = p.trace_rv_i_interrupt_ip[k];
                    r.ec   = (r.exc | r.intr) ? p.trace_rv_i_ecause_ip : 5'd0;
                    r.tval = (r.exc | r.intr) ? p.trace_rv_i_tval_ip : 32'd0;
                    q.push_back(r);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] exc, input logic [2:0] intr,
                         input logic [95:0] insn, input logic [95:0] addr,
                         input logic [4:0] ec, input logic [31:0] tv);
        trace_pkt_t p;
        p.trace_rv_i_valid_ip     = v;
        p.trace_rv_i_exception_ip = exc;
        p.trace_rv_i_interrupt_ip = intr;
        p.trace_rv_i_insn_ip      = insn;
        p.trace_rv_i_address_ip   = addr;
        p.trace_rv_i_ecause_ip    = ec;
        p.trace_rv_i_tval_ip      = tv;
        tif.trace_pkt = p;
    endtask

    task automatic idle();
        drive(3'b000, 3'b000, 3'b000, {3{32'hFFFF_FFFF}}, '0, 5'd31, 32'hFFFF_FFFF);
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        ovf_clr = 1'b0;
        tif.trace_en = 1'b1;
        tif.out_ready = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({tif.out_valid, fifo_cnt, ovf, drop_cnt} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%b cnt=%0d ovf=%b drop=%0d, need all 0",
                     tif.out_valid, fifo_cnt, ovf, drop_cnt);
        end
        n_cmp++;
        if ({tif.out_lane, tif.out_insn, tif.out_addr, tif.out_exc, tif.out_intr,
             tif.out_ecause, tif.out_tval} !== 105'd0) begin
            n_bad++;
            $display("FAIL reset_data: got insn=%h addr=%h, need 0", tif.out_insn, tif.out_addr);
        end
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk);
        #1;
        q.delete(); m_ovf = 0; m_drop = 0;
    endtask

    task automatic test_all_lanes();
        logic [31:0] exp [3];
        exp[0] = 32'hAAAA_0000; exp[1] = 32'hBBBB_1111; exp[2] = 32'hCCCC_2222;
        tif.out_ready = 1'b1;
        drive(3'b111, 3'b000, 3'b000, {exp[2], exp[1], exp[0]}, {32'h8, 32'h4, 32'h0}, 5'd0, 32'd0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (tif.out_valid !== 1'b1 || tif.out_insn !== exp[k] || tif.out_lane !== 2'(k)) begin
                n_bad++;
                $display("FAIL all_lanes[%0d]: got v=%b insn=%h lane=%0d, need v=1 insn=%h lane=%0d",
                         k, tif.out_valid, tif.out_insn, tif.out_lane, exp[k], k);
            end
            tick();
        end
        n_cmp++;
        if (tif.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL all_lanes_empty: got out_valid=%b, need 0", tif.out_valid);
        end
    endtask

    task automatic test_sparse();
        tif.out_ready = 1'b1;
        drive(3'b101, 3'b000, 3'b000, {32'h2222_2222, 32'h1111_1111, 32'h0000_0000},
              {32'h208, 32'h204, 32'h200}, 5'd0, 32'd0);
        tick();
        idle();
        n_cmp++;
        if (tif.out_valid !== 1'b1 || tif.out_lane !== 2'd0 || tif.out_insn !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL sparse_first: got v=%b lane=%0d insn=%h, need v=1 lane=0 insn=00000000",
                     tif.out_valid, tif.out_lane, tif.out_insn);
        end
        tick();
        n_cmp++;
        if (tif.out_valid !== 1'b1 || tif.out_lane !== 2'd2 || tif.out_insn !== 32'h2222_2222
            || tif.out_addr !== 32'h208) begin
            n_bad++;
            $display("FAIL sparse_second: got v=%b lane=%0d insn=%h addr=%h, need v=1 lane=2 insn=22222222 addr=208",
                     tif.out_valid, tif.out_lane, tif.out_insn, tif.out_addr);
        end
        tick();
        n_cmp++;
        if (tif.out_valid !== 1'b0 || fifo_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL sparse_empty: got v=%b cnt=%0d, need v=0 cnt=0", tif.out_valid, fifo_cnt);
        end
    endtask

    task automatic test_overflow();
        tif.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(3'b001, 3'b000, 3'b000, {64'd0, 32'h300 + 32'(i)}, '0, 5'd0, 32'd0);
            tick();
        end
        drive(3'b011, 3'b000, 3'b000, {32'd0, 32'hBAD1, 32'hBAD0}, '0, 5'd0, 32'd0);
        tick();
        n_cmp++;
        if (fifo_cnt !== 4'd7 || ovf !== 1'b1 || drop_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL overflow_drop: got cnt=%0d ovf=%b drop=%0d, need cnt=7 ovf=1 drop=2",
                     fifo_cnt, ovf, drop_cnt);
        end
        drive(3'b001, 3'b000, 3'b000, {64'd0, 32'h307}, '0, 5'd0, 32'd0);
        tick();
        n_cmp++;
        if (fifo_cnt !== 4'd8) begin
            n_bad++;
            $display("FAIL overflow_full: got cnt=%0d, need 8", fifo_cnt);
        end
        // Full FIFO with a same-cycle pop: the push is still dropped.
        tif.out_ready = 1'b1;
        drive(3'b001, 3'b000, 3'b000, {64'd0, 32'hBAD2}, '0, 5'd0, 32'd0);
        tick();
        n_cmp++;
        if (fifo_cnt !== 4'd7 || drop_cnt !== 16'd3 || tif.out_insn !== 32'h301) begin
            n_bad++;
            $display("FAIL full_pop_drop: got cnt=%0d drop=%0d head=%h, need cnt=7 drop=3 head=00000301",
                     fifo_cnt, drop_cnt, tif.out_insn);
        end
        tif.out_ready = 1'b0;
        idle();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 1'b0 || drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL ovf_clear: got ovf=%b drop=%0d, need 0/0", ovf, drop_cnt);
        end
        // Clear and drop in the same cycle: the drop wins.
        ovf_clr = 1'b1;
        drive(3'b011, 3'b000, 3'b000, {32'd0, 32'hBAD4, 32'hBAD3}, '0, 5'd0, 32'd0);
        tick();
        ovf_clr = 1'b0;
        idle();
        n_cmp++;
        if (ovf !== 1'b1 || drop_cnt !== 16'd2 || fifo_cnt !== 4'd7) begin
            n_bad++;
            $display("FAIL clr_vs_drop: got ovf=%b drop=%0d cnt=%0d, need ovf=1 drop=2 cnt=7",
                     ovf, drop_cnt, fifo_cnt);
        end
        // Drain, checking order against the pushed sequence 0x301..0x307.
        tif.out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            n_cmp++;
            if (tif.out_valid !== 1'b1 || tif.out_insn !== 32'h300 + 32'(i)) begin
                n_bad++;
                $display("FAIL overflow_drain[%0d]: got v=%b insn=%h, need v=1 insn=%h",
                         i, tif.out_valid, tif.out_insn, 32'h300 + 32'(i));
            end
            tick();
        end
        n_cmp++;
        if (tif.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow_drained: got out_valid=%b, need 0", tif.out_valid);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic test_exception();
        tif.out_ready = 1'b1;
        drive(3'b111, 3'b010, 3'b000, {32'h33, 32'h22, 32'h11}, {32'h48, 32'h44, 32'h40},
              5'd2, 32'hDEAD_BEEF);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            logic [4:0]  e_ec;
            logic [31:0] e_tv;
            e_ec = (k == 1) ? 5'd2 : 5'd0;
            e_tv = (k == 1) ? 32'hDEAD_BEEF : 32'd0;
            n_cmp++;
            if (tif.out_valid !== 1'b1 || tif.out_lane !== 2'(k) || tif.out_exc !== (k == 1)
                || tif.out_ecause !== e_ec || tif.out_tval !== e_tv) begin
                n_bad++;
                $display("FAIL exception[%0d]: got lane=%0d exc=%b ec=%0d tval=%h, need lane=%0d exc=%b ec=%0d tval=%h",
                         k, tif.out_lane, tif.out_exc, tif.out_ecause, tif.out_tval,
                         k, (k == 1), e_ec, e_tv);
            end
            tick();
        end
    endtask

    task automatic test_wrap_and_reset();
        tif.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(3'b001, 3'b000, 3'b000, {64'd0, 32'h500 + 32'(i)}, '0, 5'd0, 32'd0);
            tick();
            n_cmp++;
            if (tif.out_valid !== 1'b1 || tif.out_insn !== 32'h500 + 32'(i) || fifo_cnt !== 4'd1) begin
                n_bad++;
                $display("FAIL wrap[%0d]: got v=%b insn=%h cnt=%0d, need v=1 insn=%h cnt=1",
                         i, tif.out_valid, tif.out_insn, fifo_cnt, 32'h500 + 32'(i));
            end
        end
        tif.out_ready = 1'b0;
        drive(3'b111, 3'b000, 3'b000, {32'h3, 32'h2, 32'h1}, '0, 5'd0, 32'd0);
        tick();
        idle();
        #2;
        rst_l = 1'b0;
        #1;
        n_cmp++;
        if (tif.out_valid !== 1'b0 || fifo_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b cnt=%0d, need v=0 cnt=0", tif.out_valid, fifo_cnt);
        end
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk);
        #1;
        q.delete(); m_ovf = 0; m_drop = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rec_t h;
            drive(3'($urandom), 3'($urandom), 3'($urandom),
                  {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                  5'($urandom), $urandom);
            tif.trace_en  = ($urandom_range(0, 9) != 0);
            tif.out_ready = ($urandom_range(0, 1) != 0);
            ovf_clr       = ($urandom_range(0, 19) == 0);
            n_cmp++;
            if (tif.out_valid !== (q.size() != 0) || fifo_cnt !== 4'(q.size())
                || ovf !== m_ovf || drop_cnt !== 16'(m_drop)) begin
                n_bad++;
                $display("FAIL rand_status[%0d]: got v=%b cnt=%0d ovf=%b drop=%0d, need v=%b cnt=%0d ovf=%b drop=%0d",
                         c, tif.out_valid, fifo_cnt, ovf, drop_cnt,
                         (q.size() != 0), q.size(), m_ovf, m_drop);
            end
            if (q.size() != 0) begin
                h = q[0];
                n_cmp++;
                if ({tif.out_lane, tif.out_insn, tif.out_addr, tif.out_exc, tif.out_intr,
                     tif.out_ecause, tif.out_tval} !== {h.lane, h.insn, h.addr, h.exc, h.intr, h.ec, h.tval}) begin
                    n_bad++;
                    $display("FAIL rand_record[%0d]: got lane=%0d insn=%h addr=%h e=%b i=%b ec=%0d tval=%h, need lane=%0d insn=%h addr=%h e=%b i=%b ec=%0d tval=%h",
                             c, tif.out_lane, tif.out_insn, tif.out_addr, tif.out_exc, tif.out_intr,
                             tif.out_ecause, tif.out_tval, h.lane, h.insn, h.addr, h.exc, h.intr, h.ec, h.tval);
                end
            end
            tick();
        end
        ovf_clr = 1'b0;
        tif.trace_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_all_lanes();
        test_sparse();
        test_overflow();
        test_exception();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
